// File: rtl/systolic_pkg.sv
// Shared types and elaboration helpers for the output-stationary systolic
// matrix multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Ceiling log2 for sizing counters at elaboration time; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards a right and b down through registers and
// accumulates their product in place.
module systolic_pe #(
  parameter int DW     = 16,
  parameter int ACCW   = 40,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  output logic [DW-1:0]   out_a,
  output logic [DW-1:0]   out_b,
  output logic [ACCW-1:0] acc
);

  localparam int EXT = ACCW - 2 * DW;

  logic [DW-1:0]   a_q, b_q;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] prod_ext;
  logic            sign_bit;

  // Operands are widened to 2*DW first so the low 2*DW bits of the product are exact.
  if (SIGNED != 0) begin : g_signed
    assign prod = $signed({{DW{in_a[DW-1]}}, in_a}) * $signed({{DW{in_b[DW-1]}}, in_b});
  end else begin : g_unsigned
    assign prod = {{DW{1'b0}}, in_a} * {{DW{1'b0}}, in_b};
  end

  assign sign_bit = (SIGNED != 0) && prod[2*DW-1];

  if (EXT > 0) begin : g_ext
    assign prod_ext = {{EXT{sign_bit}}, prod};
  end else begin : g_noext
    assign prod_ext = prod;
  end

  assign acc_d = acc_q + prod_ext;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en) begin
      a_q   <= in_a;
      b_q   <= in_b;
      acc_q <= acc_d;
    end
  end

  assign out_a = a_q;
  assign out_b = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul.sv
// N x N output-stationary systolic array computing C = A * B from streamed
// unskewed A columns / B rows, then draining C one row per handshake.
module systolic_matmul
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int ACCW   = 40,
  parameter int KMAX   = 256,
  parameter int SIGNED = 0,
  localparam int KW    = clog2(KMAX + 1),
  localparam int IW    = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_vec,
  input  logic [N*DW-1:0] b_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*ACCW-1:0] out_row,
  output logic [IW-1:0]   out_idx,
  output logic            busy
);

  localparam int FW = clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
  localparam logic [IW-1:0] ROW_LAST   = IW'(N - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [IW-1:0] row_q, row_d;

  logic accept, drain_hs, clr, en;

  // Handshake outputs are gated by rst so they read low for the whole reset cycle.
  assign in_ready  = (state_q == ST_LOAD)  && !rst;
  assign out_valid = (state_q == ST_DRAIN) && !rst;
  assign busy      = (state_q != ST_IDLE)  && !rst;

  assign accept   = in_valid && in_ready;
  assign drain_hs = out_valid && out_ready;
  assign clr      = (state_q == ST_IDLE) && start;
  assign en       = (state_q == ST_LOAD) || (state_q == ST_FLUSH);

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d     = k_len;
          beat_d  = '0;
          flush_d = '0;
          row_d   = '0;
          state_d = (k_len == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (beat_d == k_q) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_q == FLUSH_LAST) state_d = ST_DRAIN;
        else                       flush_d = flush_q + 1'b1;
      end
      ST_DRAIN: begin
        if (drain_hs) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
    end
  end

  // Operands entering the array; idle LOAD cycles and FLUSH inject zeros.
  logic [DW-1:0] a_inj [N];
  logic [DW-1:0] b_inj [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_inj[i] = accept ? a_vec[i*DW +: DW] : '0;
      b_inj[i] = accept ? b_vec[i*DW +: DW] : '0;
    end
  end

  // a_link[i][j] feeds PE(i,j) from the left; b_link[i][j] feeds it from above.
  logic [DW-1:0]   a_link  [N][N+1];
  logic [DW-1:0]   b_link  [N+1][N];
  logic [ACCW-1:0] acc_arr [N][N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_link[0][0] = a_inj[0];
      assign b_link[0][0] = b_inj[0];
    end else begin : g_delay
      logic [DW-1:0] a_dly_q [i];
      logic [DW-1:0] b_dly_q [i];

      // NOTE: the delay lines are cleared on reset and on start so a new
      // product never sees operands left over from an aborted run.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int s = 0; s < i; s++) begin
            a_dly_q[s] <= '0;
            b_dly_q[s] <= '0;
          end
        end else if (en) begin
          a_dly_q[0] <= a_inj[i];
          b_dly_q[0] <= b_inj[i];
          for (int s = 1; s < i; s++) begin
            a_dly_q[s] <= a_dly_q[s-1];
            b_dly_q[s] <= b_dly_q[s-1];
          end
        end
      end

      assign a_link[i][0] = a_dly_q[i-1];
      assign b_link[0][i] = b_dly_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DW     (DW),
        .ACCW   (ACCW),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .in_a  (a_link[i][j]),
        .in_b  (b_link[i][j]),
        .out_a (a_link[i][j+1]),
        .out_b (b_link[i+1][j]),
        .acc   (acc_arr[i][j])
      );
    end
  end

  // Operands leaving the right and bottom edges have no consumer.
  logic [N-1:0] unused_tail_a, unused_tail_b;
  for (genvar i = 0; i < N; i++) begin : g_tail
    assign unused_tail_a[i] = ^a_link[i][N];
    assign unused_tail_b[i] = ^b_link[N][i];
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    assign out_row[j*ACCW +: ACCW] = acc_arr[row_q][j];
  end

  assign out_idx = row_q;

endmodule

// File: tb/tb_systolic_matmul.sv
// Randomised self-checking bench for systolic_matmul against a plain
// matrix-product reference; one unsigned and one signed instance.
module tb_systolic_matmul;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int ACCW = 40;
  localparam int KMAX = 256;
  localparam int KW   = 9;
  localparam int IW   = 2;
  localparam int KT   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, in_valid, out_ready;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_vec, b_vec;
  bit              sel;
  logic            start_u, start_s;

  logic              u_in_ready, u_out_valid, u_busy;
  logic [N*ACCW-1:0] u_out_row;
  logic [IW-1:0]     u_out_idx;
  logic              s_in_ready, s_out_valid, s_busy;
  logic [N*ACCW-1:0] s_out_row;
  logic [IW-1:0]     s_out_idx;

  logic              in_ready, out_valid, busy;
  logic [N*ACCW-1:0] out_row;
  logic [IW-1:0]     out_idx;

  assign start_u   = start && !sel;
  assign start_s   = start && sel;
  assign in_ready  = sel ? s_in_ready  : u_in_ready;
  assign out_valid = sel ? s_out_valid : u_out_valid;
  assign busy      = sel ? s_busy      : u_busy;
  assign out_row   = sel ? s_out_row   : u_out_row;
  assign out_idx   = sel ? s_out_idx   : u_out_idx;

  systolic_matmul #(.N(N), .DW(DW), .ACCW(ACCW), .KMAX(KMAX), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .start(start_u), .k_len(k_len),
    .in_valid(in_valid), .in_ready(u_in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_row(u_out_row),
    .out_idx(u_out_idx), .busy(u_busy)
  );

  systolic_matmul #(.N(N), .DW(DW), .ACCW(ACCW), .KMAX(KMAX), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start_s), .k_len(k_len),
    .in_valid(in_valid), .in_ready(s_in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_row(s_out_row),
    .out_idx(s_out_idx), .busy(s_busy)
  );

  logic [DW-1:0]   mat_a [N][KT];
  logic [DW-1:0]   mat_b [KT][N];
  logic [ACCW-1:0] c_exp [N][N];
  int nvec, nfail;

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 2^ACCW.
  task automatic compute_ref(input bit sgn, input int k);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint sum;
        sum = 0;
        for (int kk = 0; kk < k; kk++) begin
          if (sgn) sum += longint'($signed(mat_a[i][kk])) * longint'($signed(mat_b[kk][j]));
          else     sum += longint'(mat_a[i][kk]) * longint'(mat_b[kk][j]);
        end
        c_exp[i][j] = sum[ACCW-1:0];
      end
    end
  endtask

  function automatic logic [N*ACCW-1:0] exp_row(input int r);
    logic [N*ACCW-1:0] v;
    for (int j = 0; j < N; j++) v[j*ACCW +: ACCW] = c_exp[r][j];
    return v;
  endfunction

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < N; i++) for (int k = 0; k < KT; k++) mat_a[i][k] = av;
    for (int k = 0; k < KT; k++) for (int j = 0; j < N; j++) mat_b[k][j] = bv;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) for (int k = 0; k < KT; k++) mat_a[i][k] = DW'($urandom);
    for (int k = 0; k < KT; k++) for (int j = 0; j < N; j++) mat_b[k][j] = DW'($urandom);
  endtask

  task automatic start_run(input int k);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: in_valid always high, 1: toggling, 2: random gaps.
  task automatic feed(input string name, input int k, input int mode, output int beats);
    int  idx;
    bit  done, v;
    idx  = 0;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (idx >= k && !in_ready) begin
        done = 1'b1;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      for (int i = 0; i < N; i++) begin
        if (idx < k) begin
          a_vec[i*DW +: DW] = mat_a[i][idx];
          b_vec[i*DW +: DW] = mat_b[idx][i];
        end else begin
          a_vec[i*DW +: DW] = DW'($urandom);
          b_vec[i*DW +: DW] = DW'($urandom);
        end
      end
      if (v && in_ready) idx++;
      @(negedge clk);
    end
    beats = idx;
    nvec++;
    if (!done) begin
      nfail++;
      $display("FAIL %s load_timeout: accepted %0d beats, LOAD never ended (want %0d)", name, idx, k);
    end
  endtask

  // Garbage beats during FLUSH must be ignored; DRAIN follows after 2N-1 cycles.
  task automatic flush(input string name);
    int cnt;
    in_valid = 1'b1;
    a_vec = {N{DW'($urandom)}};
    b_vec = {N{DW'($urandom)}};
    nvec++;
    if (in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL %s flush_ready: in_ready=%b want 0", name, in_ready);
    end
    cnt = 0;
    while (cnt < 4 * N && out_valid !== 1'b1) begin
      @(negedge clk);
      cnt++;
    end
    in_valid = 1'b0;
    nvec++;
    if (cnt != 2 * N - 1) begin
      nfail++;
      $display("FAIL %s flush_len: %0d cycles want %0d", name, cnt, 2 * N - 1);
    end
  endtask

  task automatic drain(input string name, input int stall_row, input int stall_len, input bit rnd);
    for (int r = 0; r < N; r++) begin
      int wait_c, len;
      wait_c = 0;
      while (wait_c < 4 * N && out_valid !== 1'b1) begin
        @(negedge clk);
        wait_c++;
      end
      nvec++;
      if (out_valid !== 1'b1) begin
        nfail++;
        $display("FAIL %s row_wait: out_valid=%b for row %0d want 1", name, out_valid, r);
        out_ready = 1'b0;
        return;
      end
      nvec++;
      if (out_idx !== IW'(r)) begin
        nfail++;
        $display("FAIL %s out_idx: got %0d want %0d", name, out_idx, r);
      end
      nvec++;
      if (out_row !== exp_row(r)) begin
        nfail++;
        $display("FAIL %s row%0d: got %h want %h", name, r, out_row, exp_row(r));
      end
      len = rnd ? $urandom_range(0, 2) : ((r == stall_row) ? stall_len : 0);
      if (len > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < len; s++) begin
          @(negedge clk);
          nvec++;
          if (out_valid !== 1'b1 || out_idx !== IW'(r) || out_row !== exp_row(r)) begin
            nfail++;
            $display("FAIL %s stall%0d_row%0d: valid=%b idx=%0d row=%h want 1 %0d %h",
                     name, s, r, out_valid, out_idx, out_row, r, exp_row(r));
          end
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    nvec++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL %s idle_after: busy=%b out_valid=%b want 0 0", name, busy, out_valid);
    end
  endtask

  task automatic run_product(input string name, input bit sgn, input int k, input int mode,
                             input int stall_row, input int stall_len, input bit rnd);
    int beats;
    sel = sgn;
    compute_ref(sgn, k);
    start_run(k);
    if (k > 0) begin
      feed(name, k, mode, beats);
      nvec++;
      if (beats != k) begin
        nfail++;
        $display("FAIL %s beats: accepted %0d want %0d", name, beats, k);
      end
      flush(name);
    end
    drain(name, stall_row, stall_len, rnd);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nvec++;
    if ({u_in_ready, u_out_valid, u_busy, s_in_ready, s_out_valid, s_busy} !== 6'b0) begin
      nfail++;
      $display("FAIL reset_outputs: got %b want 000000",
               {u_in_ready, u_out_valid, u_busy, s_in_ready, s_out_valid, s_busy});
    end
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({u_in_ready, u_out_valid, u_busy, u_out_idx} !== 5'b0) begin
      nfail++;
      $display("FAIL reset_idle: got %b want 00000", {u_in_ready, u_out_valid, u_busy, u_out_idx});
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++) for (int k = 0; k < KT; k++) mat_a[i][k] = (i == k) ? DW'(1) : DW'(0);
    for (int k = 0; k < KT; k++) for (int j = 0; j < N; j++) mat_b[k][j] = DW'(k * 4 + j);
    run_product("identity", 1'b0, 4, 0, -1, 0, 1'b0);
  endtask

  task automatic test_gapped();
    fill_const(DW'(1), DW'(1));
    run_product("gapped", 1'b0, 3, 1, -1, 0, 1'b0);
  endtask

  task automatic test_signed();
    fill_const(16'hFFFF, DW'(2));
    run_product("signed", 1'b1, 5, 0, -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    fill_random();
    run_product("stall", 1'b0, 6, 2, 0, 5, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    sel = 1'b0;
    fill_random();
    start_run(8);
    in_valid = 1'b1;
    repeat (2) begin
      a_vec = {N{DW'($urandom)}};
      b_vec = {N{DW'($urandom)}};
      @(negedge clk);
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if ({busy, in_ready, out_valid} !== 3'b0) begin
      nfail++;
      $display("FAIL rst_mid_load: busy/in_ready/out_valid=%b want 000", {busy, in_ready, out_valid});
    end
    @(negedge clk);
    fill_const(DW'(2), DW'(3));
    run_product("after_rst", 1'b0, 1, 0, -1, 0, 1'b0);
  endtask

  task automatic test_zero_k();
    sel = 1'b0;
    fill_random();
    compute_ref(1'b0, 0);
    start_run(0);
    nvec++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      nfail++;
      $display("FAIL zero_k_state: busy=%b out_valid=%b want 1 1", busy, out_valid);
    end
    start = 1'b1;
    k_len = KW'(5);
    @(negedge clk);
    start = 1'b0;
    nvec++;
    if (out_valid !== 1'b1 || out_idx !== IW'(0) || in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL zero_k_start_ignored: valid=%b idx=%0d in_ready=%b want 1 0 0",
               out_valid, out_idx, in_ready);
    end
    drain("zero_k", -1, 0, 1'b0);
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL zero_k_no_restart: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      fill_random();
      run_product("random", bit'(t % 2), $urandom_range(1, KT), $urandom_range(0, 2), -1, 0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    fill_const(16'hFFFF, 16'hFFFF);
    run_product("b2b_max", 1'b0, KT, 0, -1, 0, 1'b0);
    fill_random();
    run_product("b2b_s", 1'b1, 7, 0, -1, 0, 1'b0);
    fill_random();
    run_product("b2b_u", 1'b0, 2, 0, -1, 0, 1'b0);
  endtask

  initial begin
    nvec      = 0;
    nfail     = 0;
    sel       = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_vec     = '0;
    b_vec     = '0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_gapped();
    test_signed();
    test_stall();
    test_reset_mid_load();
    test_zero_k();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
